module_ram_arbiter: RTL and testbench
=====================================

# module_ram_arbiter

Two-port arbiter that shares the single 8-bit-address/8-bit-data synchronous RAM between the CPU core and the program loader/debug port. It serialises single-beat read/write transactions, grants by round-robin, and returns read data with a valid strobe. A loader lock lets a program download own the RAM exclusively while the CPU is held via its `en` input.

## Interface
- No parameters; all widths fixed at 8 bits (256-byte RAM).
- `clk_qzt`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU transaction request; held high until `cpu_gnt`.
- `cpu_we`  in  1  1 = write, 0 = read; sampled with `cpu_req`.
- `cpu_addr`  in  8  CPU address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_gnt`  out  1  one-cycle grant pulse.
- `cpu_rdata`  out  8  read data, valid while `cpu_rvalid`.
- `cpu_rvalid`  out  1  one-cycle read-data strobe.
- `cpu_en`  out  1  drives the CPU `en`; 0 while the loader lock is held.
- `ldr_req`, `ldr_we`, `ldr_addr[7:0]`, `ldr_wdata[7:0]`  in  loader request fields, same meaning as CPU.
- `ldr_gnt`, `ldr_rdata[7:0]`, `ldr_rvalid`  out  loader grant/read return, same meaning as CPU.
- `ldr_lock`  in  1  loader requests exclusive ownership.
- `ram_addr`  out  8  registered RAM address.
- `ram_wdata`  out  8  registered RAM write data.
- `ram_we`  out  1  registered RAM write enable (one-cycle pulse).
- `ram_rdata`  in  8  RAM read data, valid the cycle after the address cycle.
- `dbg_arb`  out  8  {state[1:0], owner, last_winner, lock_active, 3'b0}.

## Operation
- States: IDLE, ACCESS, RD_WAIT.
- IDLE: if no eligible request, stay. Otherwise select winner, register its addr/wdata/we onto the RAM port, pulse its `gnt`, record owner and `last_winner`, go to ACCESS.
- ACCESS: RAM samples port. Write: deassert `ram_we`, go to IDLE. Read: go to RD_WAIT.
- RD_WAIT: capture `ram_rdata` into owner's `rdata`, pulse owner's `rvalid`, go to IDLE.
- Eligibility: CPU eligible only when `lock_active` = 0; loader always eligible.
- Round-robin: when both eligible, grant the requester that is not `last_winner`. After reset `last_winner` = loader, so the CPU wins the first tie.
- Lock: `lock_active` follows `ldr_lock`, updated only in IDLE (an in-flight CPU transaction completes). `cpu_en` = !`lock_active`.
- Requester must drop `req` in the cycle after `gnt`; a `req` still high in IDLE is a new transaction.
- `rdata` of a requester holds its last value between reads; the non-owner's outputs are untouched.
- Reset (any time, including mid-transaction): state IDLE, all `gnt`/`rvalid`/`ram_we` = 0, `ram_addr`/`ram_wdata`/`*_rdata` = 0, `lock_active` = 0, `cpu_en` = 1, `last_winner` = loader; the in-flight transaction is dropped with no `rvalid`.

## Timing
- Request seen in IDLE in cycle T: `gnt` and RAM port valid in T+1.
- Write: RAM written at end of T+1; next grant possible for a request seen in T+2 (grant in T+3).
- Read: `ram_rdata` valid in T+2; `rvalid`/`rdata` valid in T+3; arbiter back in IDLE in T+3, so next grant in T+4.
- Sustained throughput: one write per 2 cycles, one read per 3 cycles.
- `ldr_lock` rising while CPU read in flight: `cpu_en` falls the cycle after the arbiter returns to IDLE.

## Configuration
- `ARB_LDR_PRIO_EN` defined: fixed priority; loader always wins simultaneous requests, `last_winner` still tracked for `dbg_arb`.
- Undefined: round-robin as described above.

## Test plan
- Reset then CPU write `cpu_addr`=0x10, `cpu_wdata`=0xA5 -> `cpu_gnt` in T+1, `ram_we`=1 with addr 0x10/data 0xA5 in T+1, no `cpu_rvalid`.
- CPU read 0x10 after above -> `cpu_rvalid` in T+3 with `cpu_rdata`=0xA5; `ldr_rvalid` stays 0.
- Both request in same IDLE cycle, three times back-to-back -> grant order CPU, loader, CPU (with `ARB_LDR_PRIO_EN`: loader, loader, loader while `ldr_req` persists).
- `ldr_lock`=1 during CPU read of 0x20 -> read completes with `cpu_rvalid`; then `cpu_en`=0 and CPU requests ignored until `ldr_lock`=0; loader writes 0x00..0x03 succeed.
- Assert `reset`=0 in RD_WAIT of a loader read -> no `ldr_rvalid`, all outputs at reset values, `cpu_en`=1; after release CPU request granted in T+1.

Source files
------------

// File: rtl/module_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : module_ram_arbiter
// Description : Round-robin CPU/loader arbiter for a shared 256x8 sync RAM,
//               with loader lock. ARB_LDR_PRIO_EN selects fixed loader priority.
// Revision    : 1.0 - initial release
// ============================================================================
module module_ram_arbiter (
  input  logic       clk_qzt,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_gnt,
  output logic [7:0] cpu_rdata,
  output logic       cpu_rvalid,
  output logic       cpu_en,
  input  logic       ldr_req,
  input  logic       ldr_we,
  input  logic [7:0] ldr_addr,
  input  logic [7:0] ldr_wdata,
  output logic       ldr_gnt,
  output logic [7:0] ldr_rdata,
  output logic       ldr_rvalid,
  input  logic       ldr_lock,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       ram_we,
  input  logic [7:0] ram_rdata,
  output logic [7:0] dbg_arb
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ACCESS  = 2'd1;
  localparam logic [1:0] c_RD_WAIT = 2'd2;
  localparam logic       c_OWN_CPU = 1'b0;
  localparam logic       c_OWN_LDR = 1'b1;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_owner;
  logic       r_last_winner;
  logic       r_lock_active;
  logic       r_is_write;
  logic       w_cpu_elig;
  logic       w_ldr_elig;
  logic       w_start;
  logic       w_winner;
  logic       w_rd_done;

  always_ff @(posedge clk_qzt or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:    if (w_start) w_state_nxt = c_ACCESS;
      c_ACCESS:  w_state_nxt = r_is_write ? c_IDLE : c_RD_WAIT;
      c_RD_WAIT: w_state_nxt = c_IDLE;
      default:   w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    // The lock gates the CPU out only once it has been latched in IDLE.
    w_cpu_elig = cpu_req & ~r_lock_active;
    w_ldr_elig = ldr_req;
    w_start    = (r_state == c_IDLE) & (w_cpu_elig | w_ldr_elig);
    w_rd_done  = (r_state == c_RD_WAIT);
`ifdef ARB_LDR_PRIO_EN
    w_winner = w_ldr_elig ? c_OWN_LDR : c_OWN_CPU;
`else
    if (w_cpu_elig && w_ldr_elig) w_winner = ~r_last_winner;
    else if (w_ldr_elig)          w_winner = c_OWN_LDR;
    else                          w_winner = c_OWN_CPU;
`endif
  end

  always_ff @(posedge clk_qzt or negedge reset) begin
    if (!reset) begin
      r_owner       <= c_OWN_CPU;
      r_last_winner <= c_OWN_LDR;
      r_lock_active <= 1'b0;
      r_is_write    <= 1'b0;
      cpu_gnt       <= 1'b0;
      ldr_gnt       <= 1'b0;
      cpu_rvalid    <= 1'b0;
      ldr_rvalid    <= 1'b0;
      cpu_rdata     <= 8'h00;
      ldr_rdata     <= 8'h00;
      ram_addr      <= 8'h00;
      ram_wdata     <= 8'h00;
      ram_we        <= 1'b0;
    end else begin
      cpu_gnt    <= 1'b0;
      ldr_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      ldr_rvalid <= 1'b0;
      ram_we     <= 1'b0;
      if (r_state == c_IDLE) r_lock_active <= ldr_lock;
      if (w_start) begin
        r_owner       <= w_winner;
        r_last_winner <= w_winner;
        if (w_winner == c_OWN_LDR) begin
          ram_addr   <= ldr_addr;
          ram_wdata  <= ldr_wdata;
          ram_we     <= ldr_we;
          r_is_write <= ldr_we;
          ldr_gnt    <= 1'b1;
        end else begin
          ram_addr   <= cpu_addr;
          ram_wdata  <= cpu_wdata;
          ram_we     <= cpu_we;
          r_is_write <= cpu_we;
          cpu_gnt    <= 1'b1;
        end
      end
      if (w_rd_done) begin
        if (r_owner == c_OWN_LDR) begin
          ldr_rdata  <= ram_rdata;
          ldr_rvalid <= 1'b1;
        end else begin
          cpu_rdata  <= ram_rdata;
          cpu_rvalid <= 1'b1;
        end
      end
    end
  end

  assign cpu_en  = ~r_lock_active;
  assign dbg_arb = {r_state, r_owner, r_last_winner, r_lock_active, 3'b000};

endmodule
`default_nettype wire

// File: tb/tb_module_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_module_ram_arbiter
// Description : Directed vector bench for module_ram_arbiter with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_module_ram_arbiter;

  logic       clk_qzt = 1'b0;
  logic       reset = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00;
  logic       ldr_req = 1'b0, ldr_we = 1'b0, ldr_lock = 1'b0;
  logic [7:0] ldr_addr = 8'h00, ldr_wdata = 8'h00;
  logic       cpu_gnt, cpu_rvalid, cpu_en, ldr_gnt, ldr_rvalid, ram_we;
  logic [7:0] cpu_rdata, ldr_rdata, ram_addr, ram_wdata, dbg_arb;
  logic [7:0] ram_rdata = 8'h00;
  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_qzt = ~clk_qzt;

  module_ram_arbiter dut (
    .clk_qzt(clk_qzt), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_en(cpu_en),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata), .ldr_rvalid(ldr_rvalid), .ldr_lock(ldr_lock),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .dbg_arb(dbg_arb)
  );

  // Synchronous RAM: write and registered read on the same edge
  always @(posedge clk_qzt) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic       c_req, c_we;
    logic [7:0] c_addr, c_wd;
    logic       l_req, l_we;
    logic [7:0] l_addr, l_wd;
    logic       lock;
    logic       e_cg, e_lg, e_cv;
    logic [7:0] e_cd;
    logic       e_lv;
    logic [7:0] e_ld;
    logic       e_we;
    logic [7:0] e_ad, e_wd;
    logic       e_en;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic drive_idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 8'h00; ldr_wdata = 8'h00;
  endtask

  // Concatenation used for whole-row checks:
  // {cg, lg, cv, cd, lv, ld, we, ad, wd, en}
  function automatic logic [37:0] outs();
    return {cpu_gnt, ldr_gnt, cpu_rvalid, cpu_rdata, ldr_rvalid, ldr_rdata,
            ram_we, ram_addr, ram_wdata, cpu_en};
  endfunction

  logic       gw    [3];
  logic       gboth [3];
  int         gcyc  [3];
  int         ng;
  logic       exp_w [3];
  logic [7:0] exp_dbg_tie;

  initial begin
    //            creq  cwe   caddr  cwd    lreq  lwe   laddr  lwd    lock | cg    lg    cv    cd     lv    ld     we    ad     wd     en
    vecs[0]  = '{1'b1,1'b1,8'h10,8'hA5, 1'b0,1'b0,8'h00,8'h00, 1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,8'h00, 1'b1,8'h10,8'hA5,1'b1};
    vecs[1]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0, 1'b0,1'b0,1'b0,8'h00,1'b0,8'h00, 1'b0,8'h10,8'hA5,1'b1};
    vecs[2]  = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0,8'h00, 1'b0,8'h10,8'h00,1'b1};
    vecs[3]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0, 1'b0,1'b0,1'b0,8'h00,1'b0,8'h00, 1'b0,8'h10,8'h00,1'b1};
    vecs[4]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0, 1'b0,1'b0,1'b1,8'hA5,1'b0,8'h00, 1'b0,8'h10,8'h00,1'b1};
    vecs[5]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0, 1'b0,1'b0,1'b0,8'hA5,1'b0,8'h00, 1'b0,8'h10,8'h00,1'b1};
    vecs[6]  = '{1'b1,1'b1,8'h20,8'h5C, 1'b0,1'b0,8'h00,8'h00, 1'b0, 1'b1,1'b0,1'b0,8'hA5,1'b0,8'h00, 1'b1,8'h20,8'h5C,1'b1};
    vecs[7]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0, 1'b0,1'b0,1'b0,8'hA5,1'b0,8'h00, 1'b0,8'h20,8'h5C,1'b1};
    vecs[8]  = '{1'b1,1'b0,8'h20,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0, 1'b1,1'b0,1'b0,8'hA5,1'b0,8'h00, 1'b0,8'h20,8'h00,1'b1};
    vecs[9]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1, 1'b0,1'b0,1'b0,8'hA5,1'b0,8'h00, 1'b0,8'h20,8'h00,1'b1};
    vecs[10] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1, 1'b0,1'b0,1'b1,8'h5C,1'b0,8'h00, 1'b0,8'h20,8'h00,1'b1};
    vecs[11] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1, 1'b0,1'b0,1'b0,8'h5C,1'b0,8'h00, 1'b0,8'h20,8'h00,1'b0};
    vecs[12] = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1, 1'b0,1'b0,1'b0,8'h5C,1'b0,8'h00, 1'b0,8'h20,8'h00,1'b0};
    vecs[13] = '{1'b1,1'b0,8'h10,8'h00, 1'b1,1'b1,8'h00,8'h80, 1'b1, 1'b0,1'b1,1'b0,8'h5C,1'b0,8'h00, 1'b1,8'h00,8'h80,1'b0};
    vecs[14] = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1, 1'b0,1'b0,1'b0,8'h5C,1'b0,8'h00, 1'b0,8'h00,8'h80,1'b0};
    vecs[15] = '{1'b1,1'b0,8'h10,8'h00, 1'b1,1'b1,8'h01,8'h81, 1'b1, 1'b0,1'b1,1'b0,8'h5C,1'b0,8'h00, 1'b1,8'h01,8'h81,1'b0};
    vecs[16] = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1, 1'b0,1'b0,1'b0,8'h5C,1'b0,8'h00, 1'b0,8'h01,8'h81,1'b0};
    vecs[17] = '{1'b1,1'b0,8'h10,8'h00, 1'b1,1'b1,8'h02,8'h82, 1'b1, 1'b0,1'b1,1'b0,8'h5C,1'b0,8'h00, 1'b1,8'h02,8'h82,1'b0};
    vecs[18] = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1, 1'b0,1'b0,1'b0,8'h5C,1'b0,8'h00, 1'b0,8'h02,8'h82,1'b0};
    vecs[19] = '{1'b1,1'b0,8'h10,8'h00, 1'b1,1'b1,8'h03,8'h83, 1'b1, 1'b0,1'b1,1'b0,8'h5C,1'b0,8'h00, 1'b1,8'h03,8'h83,1'b0};
    vecs[20] = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1, 1'b0,1'b0,1'b0,8'h5C,1'b0,8'h00, 1'b0,8'h03,8'h83,1'b0};
    vecs[21] = '{1'b1,1'b0,8'h10,8'h00, 1'b1,1'b0,8'h02,8'h00, 1'b1, 1'b0,1'b1,1'b0,8'h5C,1'b0,8'h00, 1'b0,8'h02,8'h00,1'b0};
    vecs[22] = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1, 1'b0,1'b0,1'b0,8'h5C,1'b0,8'h00, 1'b0,8'h02,8'h00,1'b0};
    vecs[23] = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1, 1'b0,1'b0,1'b0,8'h5C,1'b1,8'h82, 1'b0,8'h02,8'h00,1'b0};
    vecs[24] = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0, 1'b0,1'b0,1'b0,8'h5C,1'b0,8'h82, 1'b0,8'h02,8'h00,1'b1};
    vecs[25] = '{1'b1,1'b0,8'h10,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0, 1'b1,1'b0,1'b0,8'h5C,1'b0,8'h82, 1'b0,8'h10,8'h00,1'b1};
    vecs[26] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0, 1'b0,1'b0,1'b0,8'h5C,1'b0,8'h82, 1'b0,8'h10,8'h00,1'b1};
    vecs[27] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0, 1'b0,1'b0,1'b1,8'hA5,1'b0,8'h82, 1'b0,8'h10,8'h00,1'b1};
    vecs[28] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0, 1'b0,1'b0,1'b0,8'hA5,1'b0,8'h82, 1'b0,8'h10,8'h00,1'b1};

`ifdef ARB_LDR_PRIO_EN
    exp_w[0] = 1'b1; exp_w[1] = 1'b1; exp_w[2] = 1'b1;
    exp_dbg_tie = 8'h18;
`else
    exp_w[0] = 1'b0; exp_w[1] = 1'b1; exp_w[2] = 1'b0;
    exp_dbg_tie = 8'h00;
`endif

    // Reset values while reset is held low
    drive_idle();
    repeat (2) @(negedge clk_qzt);
    chk("reset_outs", 64'(outs()), 64'(38'h1));
    chk("reset_dbg", 64'(dbg_arb), 64'(8'h10));
    reset = 1'b1;

    // Cycle-accurate vector table
    for (int k = 0; k < NV; k++) begin
      @(negedge clk_qzt);
      cpu_req = vecs[k].c_req; cpu_we = vecs[k].c_we;
      cpu_addr = vecs[k].c_addr; cpu_wdata = vecs[k].c_wd;
      ldr_req = vecs[k].l_req; ldr_we = vecs[k].l_we;
      ldr_addr = vecs[k].l_addr; ldr_wdata = vecs[k].l_wd;
      ldr_lock = vecs[k].lock;
      @(posedge clk_qzt); #1;
      chk($sformatf("row%0d", k), 64'(outs()),
          64'({vecs[k].e_cg, vecs[k].e_lg, vecs[k].e_cv, vecs[k].e_cd, vecs[k].e_lv,
               vecs[k].e_ld, vecs[k].e_we, vecs[k].e_ad, vecs[k].e_wd, vecs[k].e_en}));
    end

    // Tie-break sequence from a fresh reset, both requests held high
    @(negedge clk_qzt);
    drive_idle(); ldr_lock = 1'b0; reset = 1'b0;
    @(negedge clk_qzt);
    reset = 1'b1;
    @(negedge clk_qzt);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h50; cpu_wdata = 8'h11;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h60; ldr_wdata = 8'h22;
    ng = 0;
    for (int i = 0; i < 3; i++) begin gw[i] = 1'b0; gboth[i] = 1'b0; gcyc[i] = 0; end
    for (int cyc = 1; cyc <= 12 && ng < 3; cyc++) begin
      @(posedge clk_qzt); #1;
      if (cpu_gnt || ldr_gnt) begin
        gw[ng] = ldr_gnt; gboth[ng] = cpu_gnt & ldr_gnt; gcyc[ng] = cyc; ng++;
      end
    end
    @(negedge clk_qzt);
    drive_idle();
    chk("tie_grant_count", 64'(ng), 64'(3));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tie_winner%0d", i), 64'(gw[i]), 64'(exp_w[i]));
      chk($sformatf("tie_double%0d", i), 64'(gboth[i]), 64'(1'b0));
      chk($sformatf("tie_cycle%0d", i), 64'(gcyc[i]), 64'(2 * i + 1));
    end
    @(posedge clk_qzt); #1;
    chk("tie_dbg", 64'(dbg_arb), 64'(exp_dbg_tie));

    // Reset asserted while a loader read sits in RD_WAIT
    @(negedge clk_qzt);
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h10;
    @(posedge clk_qzt); #1;
    chk("rst_ldr_gnt", 64'(ldr_gnt), 64'(1'b1));
    @(negedge clk_qzt);
    drive_idle();
    @(posedge clk_qzt); #1;
    chk("rst_in_rd_wait", 64'(dbg_arb[7:6]), 64'(2'b10));
    @(negedge clk_qzt);
    reset = 1'b0;
    #1;
    chk("rst_async_outs", 64'(outs()), 64'(38'h1));
    chk("rst_async_dbg", 64'(dbg_arb), 64'(8'h10));
    @(posedge clk_qzt); #1;
    chk("rst_no_ldr_rvalid", 64'({ldr_rvalid, ldr_rdata}), 64'(9'h000));
    @(negedge clk_qzt);
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    @(posedge clk_qzt); #1;
    chk("post_rst_cpu_gnt", 64'({cpu_gnt, ram_addr}), 64'({1'b1, 8'h20}));
    @(negedge clk_qzt);
    drive_idle();
    @(posedge clk_qzt); #1;
    @(posedge clk_qzt); #1;
    chk("post_rst_cpu_read", 64'({cpu_rvalid, cpu_rdata, ldr_rvalid}), 64'({1'b1, 8'h5C, 1'b0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
